// File: rtl/dualmem_asym_if.sv
// Port bundle for the asymmetric dual-port RAM: narrow port A, wide port B,
// and the clear-in-progress flag.
interface dualmem_asym_if #(
  parameter int NARROW_W   = 16,
  parameter int RATIO      = 4,
  parameter int WIDE_DEPTH = 512,
  parameter int LANE_W     = 8
);
  localparam int WIDE_W = NARROW_W * RATIO;
  localparam int A_AW   = $clog2(WIDE_DEPTH * RATIO);
  localparam int B_AW   = $clog2(WIDE_DEPTH);
  localparam int A_LN   = NARROW_W / LANE_W;
  localparam int B_LN   = WIDE_W / LANE_W;

  logic                a_en;
  logic [A_LN-1:0]     a_we;
  logic [A_AW-1:0]     a_addr;
  logic [NARROW_W-1:0] a_din;
  logic [NARROW_W-1:0] a_dout;
  logic                a_rvalid;

  logic                b_en;
  logic [B_LN-1:0]     b_we;
  logic [B_AW-1:0]     b_addr;
  logic [WIDE_W-1:0]   b_din;
  logic [WIDE_W-1:0]   b_dout;
  logic                b_rvalid;

  logic                init_busy;

  modport master (
    output a_en, a_we, a_addr, a_din,
    input  a_dout, a_rvalid,
    output b_en, b_we, b_addr, b_din,
    input  b_dout, b_rvalid,
    input  init_busy
  );

  modport slave (
    input  a_en, a_we, a_addr, a_din,
    output a_dout, a_rvalid,
    input  b_en, b_we, b_addr, b_din,
    output b_dout, b_rvalid,
    output init_busy
  );
endinterface

// File: rtl/dualmem_asym.sv
// Single-clock asymmetric true-dual-port RAM with lane write enables,
// optional output register, read-valid strobes and a post-reset clear sequencer.
module dualmem_asym #(
  parameter int NARROW_W       = 16,
  parameter int RATIO          = 4,
  parameter int WIDE_DEPTH     = 512,
  parameter int LANE_W         = 8,
  parameter int OUT_REG        = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic           clk,
  input  logic           rst,
  dualmem_asym_if.slave  bus
);
  localparam int WIDE_W = NARROW_W * RATIO;
  localparam int A_LN   = NARROW_W / LANE_W;
  localparam int B_LN   = WIDE_W / LANE_W;
  localparam int SW     = $clog2(RATIO);
  localparam int B_AW   = $clog2(WIDE_DEPTH);
  localparam int A_AW   = B_AW + SW;

  typedef enum logic {CLEAR, READY} state_e;

  state_e            state_q, state_d;
  logic [B_AW-1:0]   cnt_q, cnt_d;
  logic              clr_we;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (&cnt_q) state_d = READY;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.init_busy = (state_q == CLEAR);

  // Request decode: both ports are deaf while clearing or in reset
  logic              ready;
  logic              a_rd, a_wr, b_rd, b_wr;
  logic [B_AW-1:0]   a_word;
  logic [SW-1:0]     a_slice;
  logic [B_LN-1:0]   a_lane_we;
  logic [WIDE_W-1:0] a_wdata;

  assign ready     = (state_q == READY) && !rst;
  assign a_rd      = ready && bus.a_en && !(|bus.a_we);
  assign a_wr      = ready && bus.a_en &&  (|bus.a_we);
  assign b_rd      = ready && bus.b_en && !(|bus.b_we);
  assign b_wr      = ready && bus.b_en &&  (|bus.b_we);
  assign a_word    = bus.a_addr[A_AW-1:SW];
  assign a_slice   = bus.a_addr[SW-1:0];
  assign a_lane_we = B_LN'(bus.a_we) << (int'(a_slice) * A_LN);
  assign a_wdata   = {RATIO{bus.a_din}};

  logic [WIDE_W-1:0] mem [WIDE_DEPTH];

  // B is applied after A so it owns any byte both ports write
  always_ff @(posedge clk) begin
    if (clr_we && !rst) begin
      mem[cnt_q] <= '0;
    end else begin
      for (int l = 0; l < B_LN; l++) begin
        if (a_wr && a_lane_we[l])
          mem[a_word][l*LANE_W +: LANE_W] <= a_wdata[l*LANE_W +: LANE_W];
        if (b_wr && bus.b_we[l])
          mem[bus.b_addr][l*LANE_W +: LANE_W] <= bus.b_din[l*LANE_W +: LANE_W];
      end
    end
  end

  // Stage p1: array read (read-first), captured only when a read is accepted
  logic [NARROW_W-1:0] a_rdata_p1;
  logic [WIDE_W-1:0]   b_rdata_p1;
  logic                a_vld_p1, b_vld_p1;

  always_ff @(posedge clk) begin
    if (OUT_REG == 0 && rst) begin
      a_rdata_p1 <= '0;
      b_rdata_p1 <= '0;
    end else begin
      if (a_rd) a_rdata_p1 <= mem[a_word][int'(a_slice)*NARROW_W +: NARROW_W];
      if (b_rd) b_rdata_p1 <= mem[bus.b_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_vld_p1 <= 1'b0;
      b_vld_p1 <= 1'b0;
    end else begin
      a_vld_p1 <= a_rd;
      b_vld_p1 <= b_rd;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      // Stage p2: output register, loads only when a read completes
      logic [NARROW_W-1:0] a_dout_p2;
      logic [WIDE_W-1:0]   b_dout_p2;
      logic                a_vld_p2, b_vld_p2;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_dout_p2 <= '0;
          b_dout_p2 <= '0;
          a_vld_p2  <= 1'b0;
          b_vld_p2  <= 1'b0;
        end else begin
          a_vld_p2 <= a_vld_p1;
          b_vld_p2 <= b_vld_p1;
          if (a_vld_p1) a_dout_p2 <= a_rdata_p1;
          if (b_vld_p1) b_dout_p2 <= b_rdata_p1;
        end
      end

      assign bus.a_dout   = a_dout_p2;
      assign bus.b_dout   = b_dout_p2;
      assign bus.a_rvalid = a_vld_p2;
      assign bus.b_rvalid = b_vld_p2;
    end else begin : g_noreg
      assign bus.a_dout   = a_rdata_p1;
      assign bus.b_dout   = b_rdata_p1;
      assign bus.a_rvalid = a_vld_p1;
      assign bus.b_rvalid = b_vld_p1;
    end
  endgenerate
endmodule

// File: tb/tb_dualmem_asym.sv
// Bench for dualmem_asym: registered-output build with clear-on-reset, plus a
// small unregistered build without clear.
module tb_dualmem_asym;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dualmem_asym_if #(.NARROW_W(16), .RATIO(4), .WIDE_DEPTH(512), .LANE_W(8)) bus1 ();
  dualmem_asym_if #(.NARROW_W(16), .RATIO(4), .WIDE_DEPTH(16),  .LANE_W(8)) bus2 ();

  dualmem_asym #(.NARROW_W(16), .RATIO(4), .WIDE_DEPTH(512), .LANE_W(8),
                 .OUT_REG(1), .CLEAR_ON_RESET(1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  dualmem_asym #(.NARROW_W(16), .RATIO(4), .WIDE_DEPTH(16), .LANE_W(8),
                 .OUT_REG(0), .CLEAR_ON_RESET(0))
    dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  int n_pass  = 0;
  int n_total = 0;
  int rv_cnt  = 0;

  typedef struct {
    logic [63:0] data;
    int          due;
  } exp_t;

  typedef struct {
    logic        a_en;
    logic [1:0]  a_we;
    logic [10:0] a_addr;
    logic [15:0] a_din;
    logic [15:0] a_exp;
    logic        b_en;
    logic [7:0]  b_we;
    logic [8:0]  b_addr;
    logic [63:0] b_din;
    logic [63:0] b_exp;
  } vec_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", nm, act, req);
  endtask

  // Scoreboard monitor for the registered build
  always @(negedge clk) begin
    if (bus1.a_rvalid) begin
      rv_cnt++;
      if (qa.size() == 0) begin
        n_total++;
        $display("FAIL a_unexpected_rvalid: got rvalid=1 at cycle %0d, required no pending read", cyc);
      end else begin
        ea = qa.pop_front();
        chk("a_data", 64'(bus1.a_dout), ea.data);
        chk("a_latency", 64'(cyc), 64'(ea.due));
      end
    end else if (qa.size() != 0 && qa[0].due < cyc) begin
      ea = qa.pop_front();
      n_total++;
      $display("FAIL a_missing_rvalid: got none by cycle %0d, required at cycle %0d", cyc, ea.due);
    end
    if (bus1.b_rvalid) begin
      rv_cnt++;
      if (qb.size() == 0) begin
        n_total++;
        $display("FAIL b_unexpected_rvalid: got rvalid=1 at cycle %0d, required no pending read", cyc);
      end else begin
        eb = qb.pop_front();
        chk("b_data", bus1.b_dout, eb.data);
        chk("b_latency", 64'(cyc), 64'(eb.due));
      end
    end else if (qb.size() != 0 && qb[0].due < cyc) begin
      eb = qb.pop_front();
      n_total++;
      $display("FAIL b_missing_rvalid: got none by cycle %0d, required at cycle %0d", cyc, eb.due);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle1();
    bus1.a_en = 1'b0; bus1.a_we = '0; bus1.a_addr = '0; bus1.a_din = '0;
    bus1.b_en = 1'b0; bus1.b_we = '0; bus1.b_addr = '0; bus1.b_din = '0;
  endtask

  task automatic idle2();
    bus2.a_en = 1'b0; bus2.a_we = '0; bus2.a_addr = '0; bus2.a_din = '0;
    bus2.b_en = 1'b0; bus2.b_we = '0; bus2.b_addr = '0; bus2.b_din = '0;
  endtask

  // Drive one vector for a cycle; reads push their expectation (latency 2)
  task automatic apply(input vec_t v);
    exp_t e;
    bus1.a_en = v.a_en; bus1.a_we = v.a_we; bus1.a_addr = v.a_addr; bus1.a_din = v.a_din;
    bus1.b_en = v.b_en; bus1.b_we = v.b_we; bus1.b_addr = v.b_addr; bus1.b_din = v.b_din;
    if (v.a_en && v.a_we == 2'b00) begin
      e.data = 64'(v.a_exp); e.due = cyc + 2; qa.push_back(e);
    end
    if (v.b_en && v.b_we == 8'h00) begin
      e.data = v.b_exp; e.due = cyc + 2; qb.push_back(e);
    end
    step();
  endtask

  // Counts cycles with init_busy high, starting just after a reset edge
  task automatic count_busy(output int n);
    n = 0;
    @(negedge clk);
    while (bus1.init_busy && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while ((qa.size() != 0 || qb.size() != 0) && k < 20) begin
      step();
      k++;
    end
    chk(nm, 64'(qa.size() + qb.size()), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish by time %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int   nb;
    int   rv0;
    vec_t v;
    logic [63:0] held_b;

    idle1();
    idle2();
    tbl.push_back('{1'b0, 2'b00, 11'd0,  16'h0,    16'h0,    1'b1, 8'hFF, 9'd3, 64'h8877665544332211, 64'h0});
    tbl.push_back('{1'b1, 2'b00, 11'd12, 16'h0,    16'h2211, 1'b0, 8'h00, 9'd0, 64'h0, 64'h0});
    tbl.push_back('{1'b1, 2'b00, 11'd13, 16'h0,    16'h4433, 1'b0, 8'h00, 9'd0, 64'h0, 64'h0});
    tbl.push_back('{1'b1, 2'b00, 11'd14, 16'h0,    16'h6655, 1'b0, 8'h00, 9'd0, 64'h0, 64'h0});
    tbl.push_back('{1'b1, 2'b00, 11'd15, 16'h0,    16'h8877, 1'b0, 8'h00, 9'd0, 64'h0, 64'h0});
    tbl.push_back('{1'b1, 2'b10, 11'd13, 16'hBEEF, 16'h0,    1'b0, 8'h00, 9'd0, 64'h0, 64'h0});
    tbl.push_back('{1'b0, 2'b00, 11'd0,  16'h0,    16'h0,    1'b1, 8'h00, 9'd3, 64'h0, 64'h88776655BE332211});
    tbl.push_back('{1'b1, 2'b11, 11'd20, 16'h1234, 16'h0,    1'b1, 8'hFF, 9'd5, 64'hFFFFFFFFFFFFFFFF, 64'h0});
    tbl.push_back('{1'b0, 2'b00, 11'd0,  16'h0,    16'h0,    1'b1, 8'h00, 9'd5, 64'h0, 64'hFFFFFFFFFFFFFFFF});
    tbl.push_back('{1'b1, 2'b00, 11'd21, 16'h0,    16'hFFFF, 1'b1, 8'hFF, 9'd5, 64'h1122334455667788, 64'h0});
    tbl.push_back('{1'b1, 2'b00, 11'd21, 16'h0,    16'h5566, 1'b1, 8'h00, 9'd5, 64'h0, 64'h1122334455667788});
    tbl.push_back('{1'b1, 2'b10, 11'd22, 16'hAB00, 16'h0,    1'b1, 8'h01, 9'd5, 64'h00000000000000EE, 64'h0});
    tbl.push_back('{1'b1, 2'b11, 11'd23, 16'h5A5A, 16'h0,    1'b1, 8'h40, 9'd5, 64'h00C3000000000000, 64'h0});
    tbl.push_back('{1'b1, 2'b00, 11'd20, 16'h0,    16'h77EE, 1'b1, 8'h00, 9'd5, 64'h0, 64'h5AC3AB44556677EE});
    tbl.push_back('{1'b1, 2'b11, 11'd0,  16'h7777, 16'h0,    1'b1, 8'h00, 9'd0, 64'h0, 64'h0});
    tbl.push_back('{1'b1, 2'b00, 11'd13, 16'h0,    16'hBE33, 1'b1, 8'h00, 9'd0, 64'h0, 64'h0000000000007777});
    tbl.push_back('{1'b1, 2'b00, 11'd1,  16'h0,    16'h0,    1'b1, 8'h00, 9'd3, 64'h0, 64'h88776655BE332211});

    // Power-on reset and reset-state checks
    repeat (2) step();
    rst = 1'b1;
    step();
    chk("rst_a_dout",    64'(bus1.a_dout), 64'd0);
    chk("rst_b_dout",    bus1.b_dout, 64'd0);
    chk("rst_a_rvalid",  64'(bus1.a_rvalid), 64'd0);
    chk("rst_b_rvalid",  64'(bus1.b_rvalid), 64'd0);
    chk("rst_init_busy", 64'(bus1.init_busy), 64'd1);
    chk("rst_busy_noclr", 64'(bus2.init_busy), 64'd0);
    rst = 1'b0;
    count_busy(nb);
    chk("clear_cycles", 64'(nb), 64'd512);
    step();

    // Last word must be cleared
    v = '{1'b0, 2'b00, 11'd0, 16'h0, 16'h0, 1'b1, 8'h00, 9'd511, 64'h0, 64'h0};
    apply(v);
    foreach (tbl[i]) apply(tbl[i]);
    idle1();
    drain("sb_drain_table");

    // Reads in flight at reset are dropped
    rv0 = rv_cnt;
    bus1.a_en = 1'b1; bus1.a_addr = 11'd12;
    bus1.b_en = 1'b1; bus1.b_addr = 9'd3;
    step();
    idle1();
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Requests while busy are ignored; a reset mid-clear restarts the count
    bus1.a_en = 1'b1; bus1.a_we = 2'b11; bus1.a_addr = 11'd4; bus1.a_din = 16'hDEAD;
    bus1.b_en = 1'b1; bus1.b_we = 8'h00; bus1.b_addr = 9'd3;
    repeat (100) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    count_busy(nb);
    idle1();
    chk("restart_clear_cycles", 64'(nb), 64'd512);
    chk("busy_no_rvalid", 64'(rv_cnt - rv0), 64'd0);
    step();
    v = '{1'b1, 2'b00, 11'd4, 16'h0, 16'h0, 1'b1, 8'h00, 9'd3, 64'h0, 64'h0};
    apply(v);
    idle1();
    drain("sb_drain_reset");

    // Unregistered build: latency 1, output holds while idle
    bus2.b_en = 1'b1; bus2.b_we = 8'hFF; bus2.b_addr = 4'd2; bus2.b_din = 64'hCAFEF00D12345678;
    step();
    idle2();
    bus2.a_en = 1'b1; bus2.a_addr = 6'd9;
    bus2.b_en = 1'b1; bus2.b_addr = 4'd2;
    chk("r0_write_no_rvalid", 64'(bus2.b_rvalid), 64'd0);
    step();
    idle2();
    chk("r0_a_rvalid", 64'(bus2.a_rvalid), 64'd1);
    chk("r0_a_dout",   64'(bus2.a_dout), 64'h1234);
    chk("r0_b_rvalid", 64'(bus2.b_rvalid), 64'd1);
    chk("r0_b_dout",   bus2.b_dout, 64'hCAFEF00D12345678);
    held_b = 64'hCAFEF00D12345678;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("r0_idle_a_rvalid", 64'(bus2.a_rvalid), 64'd0);
      chk("r0_idle_b_rvalid", 64'(bus2.b_rvalid), 64'd0);
      chk("r0_idle_a_hold",   64'(bus2.a_dout), 64'h1234);
      chk("r0_idle_b_hold",   bus2.b_dout, held_b);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
